// File: rtl/pll_lock_sequencer.sv
// PLL power-up / relock sequencer: pulses the PLL reset, waits for a stable lock
// with timeout and bounded retries, then releases the downstream system reset.
module pll_lock_sequencer #(
   parameter  int unsigned PLL_RST_CYCLES = 10,
   parameter  int unsigned LOCK_TIMEOUT   = 10000,
   parameter  int unsigned LOCK_STABLE    = 64,
   parameter  int unsigned MAX_RETRIES    = 3,
   localparam int unsigned RW             = $clog2(MAX_RETRIES + 1)
) (
   input  logic          clk_100MHz,
   input  logic          reset,
   input  logic          pll_locked,
   input  logic          restart,
   output logic          pll_reset,
   output logic          sys_reset_n,
   output logic          ready,
   output logic          fault,
   output logic          lock_lost,
   output logic [RW-1:0] retry_count
);

   localparam int unsigned CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_STABLE) ? CNT_MAX_A : LOCK_STABLE;
   localparam int unsigned CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABILIZE = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [CW-1:0]   w_cnt_inc;
   logic [RW-1:0]   r_retry;
   logic [RW-1:0]   w_retry_nxt;
   logic            w_fail;
   logic            w_lock_lost_nxt;
   logic            r_sync1;
   logic            r_locked_s;
   logic            r_pll_reset;
   logic            r_sys_reset_n;
   logic            r_ready;
   logic            r_fault;
   logic            r_lock_lost;

   // Two-flop synchroniser for the asynchronous lock indicator
   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         r_sync1    <= 1'b0;
         r_locked_s <= 1'b0;
      end else begin
         r_sync1    <= pll_locked;
         r_locked_s <= r_sync1;
      end
   end

   // Saturating increment so a long stall can never wrap the counter
   assign w_cnt_inc = (r_cnt == CW'(CNT_MAX - 1)) ? r_cnt : r_cnt + CW'(1);

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = w_cnt_inc;
      w_retry_nxt     = r_retry;
      w_fail          = 1'b0;
      w_lock_lost_nxt = 1'b0;
      if (restart) begin
         w_state_nxt = S_RESET_PLL;
         w_cnt_nxt   = '0;
         w_retry_nxt = '0;
      end else begin
         case (r_state)
            S_RESET_PLL: begin
               if (r_cnt == CW'(PLL_RST_CYCLES - 1)) begin
                  w_state_nxt = S_WAIT_LOCK;
                  w_cnt_nxt   = '0;
               end
            end
            S_WAIT_LOCK: begin
               if (r_locked_s) begin
                  w_state_nxt = S_STABILIZE;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                  w_fail = 1'b1;
               end
            end
            S_STABILIZE: begin
               if (!r_locked_s) begin
                  w_fail = 1'b1;
               end else if (r_cnt == CW'(LOCK_STABLE - 1)) begin
                  w_state_nxt = S_RUN;
                  w_cnt_nxt   = '0;
               end
            end
            S_RUN: begin
               w_cnt_nxt = '0;
               if (!r_locked_s) begin
                  w_state_nxt     = S_RESET_PLL;
                  w_retry_nxt     = '0;
                  w_lock_lost_nxt = 1'b1;
               end
            end
            S_FAULT: begin
               w_cnt_nxt = '0;
            end
            default: begin
               w_state_nxt = S_RESET_PLL;
               w_cnt_nxt   = '0;
               w_retry_nxt = '0;
            end
         endcase
         // A failed attempt either retries the PLL reset or gives up
         if (w_fail) begin
            w_cnt_nxt = '0;
            if (r_retry == RW'(MAX_RETRIES)) begin
               w_state_nxt = S_FAULT;
            end else begin
               w_state_nxt = S_RESET_PLL;
               w_retry_nxt = r_retry + RW'(1);
            end
         end
      end
   end

   // State and outputs, with outputs decoded from the next state
   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         r_state       <= S_RESET_PLL;
         r_cnt         <= '0;
         r_retry       <= '0;
         r_pll_reset   <= 1'b1;
         r_sys_reset_n <= 1'b0;
         r_ready       <= 1'b0;
         r_fault       <= 1'b0;
         r_lock_lost   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_retry       <= w_retry_nxt;
         r_pll_reset   <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAULT);
         r_sys_reset_n <= (w_state_nxt == S_RUN);
         r_ready       <= (w_state_nxt == S_RUN);
         r_fault       <= (w_state_nxt == S_FAULT);
         r_lock_lost   <= w_lock_lost_nxt;
      end
   end

   assign pll_reset   = r_pll_reset;
   assign sys_reset_n = r_sys_reset_n;
   assign ready       = r_ready;
   assign fault       = r_fault;
   assign lock_lost   = r_lock_lost;
   assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: every output change is matched against
// a hand-timed expected event {edge number, output vector}.
module tb_pll_lock_sequencer;

   localparam int unsigned RW = 2;

   typedef struct {
      int         cyc;
      logic [6:0] outs;
      int         tag;
   } exp_t;

   logic          clk_100MHz = 1'b0;
   logic          reset;
   logic          pll_locked;
   logic          restart;
   logic          pll_reset;
   logic          sys_reset_n;
   logic          ready;
   logic          fault;
   logic          lock_lost;
   logic [RW-1:0] retry_count;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t q[$];
   logic [6:0] prev = 7'b1000000;

   pll_lock_sequencer #(
      .PLL_RST_CYCLES(10),
      .LOCK_TIMEOUT  (100),
      .LOCK_STABLE   (8),
      .MAX_RETRIES   (2)
   ) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .pll_locked (pll_locked),
      .restart    (restart),
      .pll_reset  (pll_reset),
      .sys_reset_n(sys_reset_n),
      .ready      (ready),
      .fault      (fault),
      .lock_lost  (lock_lost),
      .retry_count(retry_count)
   );

   always #5 clk_100MHz = ~clk_100MHz;
   always @(posedge clk_100MHz) cyc <= cyc + 1;

   // {pll_reset, sys_reset_n, ready, fault, lock_lost, retry_count}
   function automatic logic [6:0] mk(input logic pr, input logic sr, input logic rd,
                                     input logic ft, input logic ll, input logic [1:0] rc);
      return {pr, sr, rd, ft, ll, rc};
   endfunction

   function automatic logic [6:0] outs_now();
      return {pll_reset, sys_reset_n, ready, fault, lock_lost, retry_count};
   endfunction

   task automatic chk(input string name, input logic [6:0] got, input logic [6:0] req);
      n_chk++;
      if (got === req) n_pass++;
      else $display("FAIL %s: got=%b required=%b (edge %0d)", name, got, req, cyc);
   endtask

   task automatic push(input int c, input logic [6:0] o, input int tag);
      exp_t e;
      e.cyc  = c;
      e.outs = o;
      e.tag  = tag;
      q.push_back(e);
   endtask

   task automatic wait_to(input int n);
      while (cyc < n) @(negedge clk_100MHz);
   endtask

   // Monitor: every change of the output vector must match the next expected event
   always @(negedge clk_100MHz) begin
      logic [6:0] cur;
      exp_t       e;
      cur = outs_now();
      if (cur !== prev) begin
         n_chk++;
         if (q.size() == 0) begin
            $display("FAIL unexpected_change: edge=%0d outs=%b required=no change from %b", cyc, cur, prev);
         end else begin
            e = q.pop_front();
            if (cyc == e.cyc && cur === e.outs) n_pass++;
            else $display("FAIL ev%0d: edge=%0d outs=%b required edge=%0d outs=%b",
                          e.tag, cyc, cur, e.cyc, e.outs);
         end
         n_chk++;
         if (ready === sys_reset_n) n_pass++;
         else $display("FAIL ready_eq_sysrst: ready=%b required=%b (edge %0d)", ready, sys_reset_n, cyc);
         prev = cur;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: edge=%0d required=finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int b, k, j, r, w;
      reset      = 1'b1;
      pll_locked = 1'b0;
      restart    = 1'b0;
      #1 reset = 1'b0;
      repeat (3) @(negedge clk_100MHz);
      chk("reset_state", outs_now(), mk(1, 0, 0, 0, 0, 0));

      // Power-up: pll_reset for 10 edges, release 10 edges after the first locked sample
      reset = 1'b1;
      b = cyc;
      push(b + 10, mk(0, 0, 0, 0, 0, 0), 1);
      wait_to(b + 20);
      pll_locked = 1'b1;
      k = cyc + 1;
      push(k + 10, mk(0, 1, 1, 0, 0, 0), 2);

      // Loss of lock in RUN
      wait_to(k + 20);
      pll_locked = 1'b0;
      j = cyc + 1;
      push(j + 2,  mk(1, 0, 0, 0, 1, 0), 3);
      push(j + 3,  mk(1, 0, 0, 0, 0, 0), 4);
      push(j + 12, mk(0, 0, 0, 0, 0, 0), 5);
      wait_to(j + 20);
      pll_locked = 1'b1;
      k = cyc + 1;
      push(k + 10, mk(0, 1, 1, 0, 0, 0), 6);

      // Restart, then a 4-cycle lock glitch during STABILIZE
      wait_to(k + 20);
      pll_locked = 1'b0;
      restart    = 1'b1;
      r = cyc + 1;
      push(r,      mk(1, 0, 0, 0, 0, 0), 7);
      push(r + 10, mk(0, 0, 0, 0, 0, 0), 8);
      @(negedge clk_100MHz);
      restart = 1'b0;
      wait_to(r + 15);
      pll_locked = 1'b1;
      k = cyc + 1;
      push(k + 6,  mk(1, 0, 0, 0, 0, 1), 9);
      push(k + 16, mk(0, 0, 0, 0, 0, 1), 10);
      push(k + 25, mk(0, 1, 1, 0, 0, 1), 11);
      wait_to(k + 3);
      pll_locked = 1'b0;
      wait_to(k + 7);
      pll_locked = 1'b1;

      // Restart on the same edge the FSM sees the lock fall: no lock_lost
      wait_to(k + 35);
      pll_locked = 1'b0;
      j = cyc + 1;
      wait_to(j + 1);
      restart = 1'b1;
      push(j + 2,  mk(1, 0, 0, 0, 0, 0), 12);
      push(j + 12, mk(0, 0, 0, 0, 0, 0), 13);
      @(negedge clk_100MHz);
      restart = 1'b0;

      // No lock: three timeouts then FAULT, cleared by restart
      w = j + 12;
      push(w + 100, mk(1, 0, 0, 0, 0, 1), 14);
      push(w + 110, mk(0, 0, 0, 0, 0, 1), 15);
      push(w + 210, mk(1, 0, 0, 0, 0, 2), 16);
      push(w + 220, mk(0, 0, 0, 0, 0, 2), 17);
      push(w + 320, mk(1, 0, 0, 1, 0, 2), 18);
      wait_to(w + 340);
      chk("fault_hold", outs_now(), mk(1, 0, 0, 1, 0, 2));
      restart = 1'b1;
      r = cyc + 1;
      push(r,      mk(1, 0, 0, 0, 0, 0), 19);
      push(r + 10, mk(0, 0, 0, 0, 0, 0), 20);
      @(negedge clk_100MHz);
      restart = 1'b0;

      // Async reset during STABILIZE acts before the next edge
      wait_to(r + 12);
      pll_locked = 1'b1;
      k = cyc + 1;
      wait_to(k + 5);
      @(posedge clk_100MHz);
      #2;
      push(cyc, mk(1, 0, 0, 0, 0, 0), 21);
      reset = 1'b0;
      #1;
      chk("async_reset", outs_now(), mk(1, 0, 0, 0, 0, 0));

      // Release with the lock already present: synchroniser restarts from 0
      repeat (2) @(negedge clk_100MHz);
      reset = 1'b1;
      b = cyc;
      push(b + 10, mk(0, 0, 0, 0, 0, 0), 22);
      push(b + 19, mk(0, 1, 1, 0, 0, 0), 23);
      wait_to(b + 30);

      n_chk++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL pending_events: got=%0d required=0 (next ev%0d)", q.size(), q[0].tag);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
